// File: rtl/decoder3to8_seq.sv
// Sequenced 3-to-8 decoder. Codes arrive over valid/ready into a small FIFO
// and are replayed one at a time as a registered one-hot strobe on Y. Each
// strobe is held for HOLD cycles and is followed by GAP all-zero cycles.
module decoder3to8_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
  output logic                     in_ready,
  output logic [7:0]               Y,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [2:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Sequencer state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_y;

  logic             w_push;
  logic             w_pop;
  logic             w_have;
  logic [7:0]       w_head_onehot;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_y_nxt;

  // A full FIFO refuses input even on a cycle where the sequencer pops.
  assign in_ready      = (r_level < LVL_W'(DEPTH)) && !rst;
  assign w_push        = in_valid && in_ready;
  assign w_have        = (r_level != '0);
  assign w_head_onehot = 8'd1 << r_mem[r_rd_ptr];

  assign Y     = r_y;
  assign level = r_level;

  // Write accepted codes into the FIFO array.
  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are meaningful, so flushing them is enough and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_code;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

  // State register: FSM state, down-counter and the registered strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Next-state logic: decide transitions, counter reloads and FIFO pops.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_have) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (GAP > 0) begin
          w_cnt_nxt   = GAP_LD;
          w_state_nxt = S_GAP;
        end else if (w_have) begin
          // Back-to-back codes with no zero cycle in between.
          w_pop     = 1'b1;
          w_cnt_nxt = HOLD_LD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_have) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = S_DRIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: load a fresh strobe on a pop, hold it through DRIVE, else zero.
  always_comb begin
    w_y_nxt = '0;
    if (w_pop) begin
      w_y_nxt = w_head_onehot;
    end else if (w_state_nxt == S_DRIVE) begin
      w_y_nxt = r_y;
    end
    busy = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Self-checking bench for decoder3to8_seq. A timeline model derived from the
// behavioural rules predicts Y, busy, level and in_ready every cycle: each
// accepted code starts at max(push_edge+1, previous_start+HOLD+GAP) and is
// visible for HOLD edges; the FSM stays busy until start+HOLD+GAP.
module tb_decoder3to8_seq;

  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] y;
  logic       busy;
  logic [2:0] level;

  // Second instance with no gap, for the back-to-back case.
  logic       in_valid0;
  logic [2:0] in_code0;
  logic       in_ready0;
  logic [7:0] y0;
  logic       busy0;
  logic [2:0] level0;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int q_code[$];
  int q_time[$];
  int m_t         = 0;
  int m_have      = 0;
  int m_start     = 0;
  int m_code      = 0;
  int m_next_free = 0;
  logic last_acc  = 1'b0;

  int acc_log[$];
  int obs[$];
  logic [7:0] prev_y = 8'h00;

  decoder3to8_seq #(.HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .Y        (y),
    .busy     (busy),
    .level    (level)
  );

  decoder3to8_seq #(.HOLD(HOLD), .GAP(0), .DEPTH(DEPTH)) u_dut_gap0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid0),
    .in_code  (in_code0),
    .in_ready (in_ready0),
    .Y        (y0),
    .busy     (busy0),
    .level    (level0)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Apply inputs in the low phase, advance one rising edge, update the model,
  // then compare the registered outputs on the following falling edge.
  task automatic step(input logic v, input logic [2:0] c);
    logic exp_ready;
    logic acc;
    logic [7:0] exp_y;
    logic exp_busy;
    in_valid = v;
    in_code  = c;
    #1;
    exp_ready = !rst && (q_code.size() < DEPTH);
    check("in_ready", in_ready, exp_ready);
    acc = v && exp_ready;
    last_acc = acc;
    @(posedge clk);
    m_t++;
    if (rst) begin
      q_code.delete();
      q_time.delete();
      m_have      = 0;
      m_next_free = 0;
    end else begin
      if (acc) begin
        q_code.push_back(int'(c));
        q_time.push_back(m_t);
        acc_log.push_back(int'(c));
      end
      if (q_code.size() > 0 && q_time[0] < m_t && m_next_free <= m_t) begin
        m_have      = 1;
        m_start     = m_t;
        m_code      = q_code.pop_front();
        void'(q_time.pop_front());
        m_next_free = m_t + HOLD + GAP;
      end
    end
    exp_y    = (m_have != 0 && m_t < m_start + HOLD) ? (8'd1 << m_code) : 8'd0;
    exp_busy = (m_have != 0 && m_t < m_start + HOLD + GAP);
    @(negedge clk);
    check("y", y, exp_y);
    check("busy", busy, exp_busy);
    check("level", level, q_code.size());
  endtask

  // Every cycle: Y stays zero or one-hot, level stays within DEPTH, and each
  // new strobe is logged so the emitted order can be compared with the input.
  always @(posedge clk) begin
    int idx;
    #2;
    check("onehot0_y", $onehot0(y), 1'b1);
    check("onehot0_y_gap0", $onehot0(y0), 1'b1);
    check("level_le_depth", (level <= DEPTH), 1'b1);
    if (y != 8'h00 && prev_y == 8'h00) begin
      idx = 0;
      for (int b = 0; b < 8; b++) if (y[b]) idx = b;
      obs.push_back(idx);
    end
    prev_y = y;
  end

  initial begin
    int n;
    int budget;
    void'($urandom(32'd2024));
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    in_valid0 = 1'b0;
    in_code0  = 3'd0;
    @(negedge clk);

    // Reset state, then inputs driven during reset must be ignored.
    check("reset_y", y, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_level", level, 3'd0);
    check("reset_in_ready", in_ready, 1'b0);
    repeat (3) step(1'b1, 3'd5);
    rst = 1'b0;
    repeat (6) step(1'b0, 3'd0);
    check("reset_nothing_emitted", obs.size(), 0);

    // Single code 3: Y=08 for HOLD cycles, busy through the gap.
    step(1'b1, 3'd3);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 3'd0);
      check("single_y", y, (k <= HOLD) ? 8'h08 : 8'h00);
      check("single_busy", busy, (k <= HOLD + GAP));
    end

    // Burst of six codes from IDLE; later codes wait for space.
    obs.delete();
    n = 0;
    budget = 0;
    while (n < 6 && budget < 100) begin
      step(1'b1, n[2:0]);
      if (last_acc) n++;
      budget++;
    end
    check("burst_accepted", n, 6);
    repeat (35) step(1'b0, 3'd0);
    check("burst_count", obs.size(), 6);
    for (int i = 0; i < obs.size() && i < 6; i++) check("burst_order", obs[i], i);

    // GAP=0 instance: 7 then 0 with no zero cycle between them.
    check("gap0_ready", in_ready0, 1'b1);
    in_valid0 = 1'b1;
    in_code0  = 3'd7;
    step(1'b0, 3'd0);
    in_code0  = 3'd0;
    step(1'b0, 3'd0);
    in_valid0 = 1'b0;
    for (int k = 0; k < 2 * HOLD; k++) begin
      check("gap0_y", y0, (k < HOLD) ? 8'h80 : 8'h01);
      step(1'b0, 3'd0);
    end
    check("gap0_y_end", y0, 8'h00);
    check("gap0_busy_end", busy0, 1'b0);

    // Reset in the middle of DRIVE with three codes queued.
    obs.delete();
    step(1'b1, 3'd6);
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    step(1'b1, 3'd3);
    check("midrst_queued", level, 3'd3);
    step(1'b0, 3'd0);
    rst = 1'b1;
    step(1'b0, 3'd0);
    check("midrst_y", y, 8'h00);
    check("midrst_level", level, 3'd0);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (20) step(1'b0, 3'd0);
    check("midrst_emitted", obs.size(), 1);
    if (obs.size() > 0) check("midrst_first", obs[0], 6);

    // Randomized sweep: 200 accepted codes with random valid gaps.
    acc_log.delete();
    obs.delete();
    n = 0;
    budget = 0;
    while (n < 200 && budget < 5000) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      if (last_acc) n++;
      budget++;
    end
    check("sweep_accepted", n, 200);
    repeat (40) step(1'b0, 3'd0);
    check("sweep_count", obs.size(), acc_log.size());
    for (int i = 0; i < acc_log.size() && i < obs.size(); i++) begin
      check("sweep_order", obs[i], acc_log[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
